// File: rtl/io_cond_pkg.sv
// rtl/io_cond_pkg.sv - shared constants and helpers for the DM input conditioner
package io_cond_pkg;

  localparam int IO_WIDTH            = 9;
  localparam int IO_DEBOUNCE_DEFAULT = 1000;

  // Debounce counter width: clog2 of the cycle count, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_input_conditioner_if.sv
// rtl/io_input_conditioner_if.sv - status/event bus between the conditioner and its poller
interface io_input_conditioner_if import io_cond_pkg::*; #(
  parameter int WIDTH = IO_WIDTH
);

  logic [WIDTH-1:0] STATE;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic [WIDTH-1:0] CHANGE_MASK;
  logic             CHANGED;
  logic             CHANGE_ACK;

  modport master (
    output STATE,
    output RISE,
    output FALL,
    output CHANGE_MASK,
    output CHANGED,
    input  CHANGE_ACK
  );

  modport slave (
    input  STATE,
    input  RISE,
    input  FALL,
    input  CHANGE_MASK,
    input  CHANGED,
    output CHANGE_ACK
  );

endinterface

// File: rtl/io_input_conditioner_debounce_ch.sv
// rtl/io_input_conditioner_debounce_ch.sv - one channel: synchronizer, debounce counter, level and edge pulses
module io_debounce_ch import io_cond_pkg::*; #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic state,
  output logic rise,
  output logic fall,
  output logic rise_nxt,
  output logic fall_nxt
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   s;
  logic                   accept;

  assign s        = sync_q[SYNC_STAGES-1];
  // A new level is taken once it has differed from STATE for the full window;
  // the counter never passes CNT_LAST because reaching it forces a reload.
  assign accept   = (s != state) && (cnt_q == CNT_LAST);
  assign rise_nxt = accept & s;
  assign fall_nxt = accept & ~s;

  // Bring the asynchronous pad level into the CLK domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // Debounce filter: any return to the current level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      state <= 1'b0;
    end else if (s == state) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      state <= s;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Edge pulses land on the same edge as the STATE update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// rtl/io_input_conditioner.sv - per-channel conditioning plus sticky change mask with ack
module io_input_conditioner import io_cond_pkg::*; #(
  parameter int WIDTH           = IO_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic [WIDTH-1:0]         PAD_Y,
  io_input_conditioner_if.master   st
);

  logic [WIDTH-1:0] state_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;
  logic [WIDTH-1:0] mask_q;
  logic             changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    io_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (CLK),
      .rst_n    (RESETN),
      .pad      (PAD_Y[i]),
      .state    (state_vec[i]),
      .rise     (rise_vec[i]),
      .fall     (fall_vec[i]),
      .rise_nxt (rise_nxt[i]),
      .fall_nxt (fall_nxt[i])
    );
  end

  // Sticky mask: ack clears old events, but an event on the ack edge survives
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      mask_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      mask_q    <= (st.CHANGE_ACK ? '0 : mask_q) | rise_nxt | fall_nxt;
      changed_q <= |mask_q;
    end
  end

  assign st.STATE       = state_vec;
  assign st.RISE        = rise_vec;
  assign st.FALL        = fall_vec;
  assign st.CHANGE_MASK = mask_q;
  assign st.CHANGED     = changed_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// tb/tb_io_input_conditioner.sv - directed and random checks of io_input_conditioner against a window model
module tb_io_input_conditioner;

  localparam int W  = 9;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int HL = SS + DC;

  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic [W-1:0] PAD_Y = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pad samples per edge, newest first
  logic [W-1:0] hist [0:HL-1];
  logic [W-1:0] m_state, m_rise, m_fall, m_mask;
  logic         m_changed;

  io_input_conditioner_if #(.WIDTH(W)) bus ();

  io_input_conditioner #(
    .WIDTH           (W),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .PAD_Y  (PAD_Y),
    .st     (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < HL; k++) hist[k] = '0;
    m_state   = '0;
    m_rise    = '0;
    m_fall    = '0;
    m_mask    = '0;
    m_changed = 1'b0;
  endtask

  task automatic chk_model();
    chk("state",   bus.STATE,       m_state);
    chk("rise",    bus.RISE,        m_rise);
    chk("fall",    bus.FALL,        m_fall);
    chk("mask",    bus.CHANGE_MASK, m_mask);
    chk("changed", {{(W-1){1'b0}}, bus.CHANGED}, {{(W-1){1'b0}}, m_changed});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"},   bus.STATE,       '0);
    chk({tag, "_rise"},    bus.RISE,        '0);
    chk({tag, "_fall"},    bus.FALL,        '0);
    chk({tag, "_mask"},    bus.CHANGE_MASK, '0);
    chk({tag, "_changed"}, {{(W-1){1'b0}}, bus.CHANGED}, '0);
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge.
  // A level is accepted when the last DC synchronized samples all oppose the current level.
  task automatic step(input logic [W-1:0] pad, input logic ack);
    logic [W-1:0] all_one, all_zero;
    PAD_Y          = pad;
    bus.CHANGE_ACK = ack;
    @(posedge CLK);
    all_one  = '1;
    all_zero = '1;
    for (int k = SS - 1; k <= SS + DC - 2; k++) begin
      all_one  = all_one & hist[k];
      all_zero = all_zero & ~hist[k];
    end
    m_changed = |m_mask;
    m_rise    = ~m_state & all_one;
    m_fall    = m_state & all_zero;
    m_state   = m_state ^ (m_rise | m_fall);
    m_mask    = (ack ? '0 : m_mask) | m_rise | m_fall;
    for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = pad;
    #1;
    chk_model();
  endtask

  initial begin
    int           hold [W];
    logic [W-1:0] rpad;

    bus.CHANGE_ACK = 1'b0;
    model_reset();

    // Reset with all pads high, then initial level appears as rise on edge 6
    PAD_Y = 9'h1FF;
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RESETN = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(9'h1FF, 1'b0);
      if (e == 5) chk("rel_state_e5", bus.STATE, 9'h000);
      if (e == 6) begin
        chk("rel_rise_e6",  bus.RISE,        9'h1FF);
        chk("rel_state_e6", bus.STATE,       9'h1FF);
        chk("rel_mask_e6",  bus.CHANGE_MASK, 9'h1FF);
        chk("rel_chg_e6",   {8'h0, bus.CHANGED}, 9'h000);
      end
      if (e == 7) begin
        chk("rel_chg_e7",  {8'h0, bus.CHANGED}, 9'h001);
        chk("rel_rise_e7", bus.RISE, 9'h000);
      end
    end
    step(9'h1FF, 1'b1);
    chk("ack_clear_mask", bus.CHANGE_MASK, 9'h000);
    chk("ack_chg_hold",   {8'h0, bus.CHANGED}, 9'h001);
    step(9'h1FF, 1'b0);
    chk("ack_chg_drop",   {8'h0, bus.CHANGED}, 9'h000);

    // Falling edge on channel 8
    for (int e = 1; e <= 8; e++) begin
      step(9'h0FF, 1'b0);
      if (e == 6) begin
        chk("fall8_e6", bus.FALL,        9'h100);
        chk("mask8_e6", bus.CHANGE_MASK, 9'h100);
      end
      if (e == 7) chk("fall8_e7", bus.FALL, 9'h000);
    end

    // Bring everything low and clear the mask
    repeat (8) step(9'h000, 1'b0);
    step(9'h000, 1'b1);
    step(9'h000, 1'b0);

    // Glitch of three cycles on channel 3 must be discarded
    for (int e = 1; e <= 12; e++) begin
      step((e <= 3) ? 9'h008 : 9'h000, 1'b0);
      chk("glitch_state", bus.STATE,       9'h000);
      chk("glitch_rise",  bus.RISE,        9'h000);
      chk("glitch_mask",  bus.CHANGE_MASK, 9'h000);
    end

    // Ack colliding with a new acceptance on channel 2
    repeat (6) step(9'h001, 1'b0);
    chk("coll_pre_mask", bus.CHANGE_MASK, 9'h001);
    for (int e = 1; e <= 6; e++) step(9'h005, e == 6);
    chk("coll_mask",    bus.CHANGE_MASK, 9'h004);
    chk("coll_changed", {8'h0, bus.CHANGED}, 9'h001);
    step(9'h005, 1'b0);
    chk("coll_changed2", {8'h0, bus.CHANGED}, 9'h001);

    repeat (8) step(9'h000, 1'b0);
    step(9'h000, 1'b1);
    step(9'h000, 1'b0);

    // Reset in the middle of a debounce count on channel 4
    repeat (5) step(9'h010, 1'b0);
    RESETN = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("midrst_hold");
    RESETN = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(9'h010, 1'b0);
      if (e == 5) chk("midrst_state_e5", bus.STATE, 9'h000);
      if (e == 6) chk("midrst_rise_e6",  bus.RISE,  9'h010);
    end

    // Random bouncing of all channels with hold times of 1 to 10 cycles
    rpad = 9'h010;
    for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 10);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < W; i++) begin
        hold[i] = hold[i] - 1;
        if (hold[i] == 0) begin
          rpad[i] = ~rpad[i];
          hold[i] = $urandom_range(1, 10);
        end
      end
      step(rpad, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Conditions the nine LVCMOS33 input-buffer outputs of the DM interface before any fabric logic uses them. Each channel gets a synchronizer, a debounce filter and edge detection. A sticky change-mask with an acknowledge handshake lets the command/status logic poll for input events without missing short-lived changes.

## Interface
- `WIDTH`, default 9: number of input channels.
- `SYNC_STAGES`, default 2: synchronizer flops per channel; legal values 2 or 3.
- `DEBOUNCE_CYCLES`, default 1000: consecutive CLK cycles a new level must persist before it is accepted; legal range 1 to 2^20.
- `CLK`, in, 1: single fabric clock; all logic is on its rising edge.
- `RESETN`, in, 1: asynchronous active-low reset.
- `PAD_Y`, in, WIDTH: raw buffered pad levels; asynchronous to CLK.
- `STATE`, out, WIDTH: debounced, synchronized level of each channel.
- `RISE`, out, WIDTH: one-cycle pulse when the matching `STATE` bit goes 0→1.
- `FALL`, out, WIDTH: one-cycle pulse when the matching `STATE` bit goes 1→0.
- `CHANGE_MASK`, out, WIDTH: sticky bit per channel; set on any accepted change of that channel.
- `CHANGED`, out, 1: OR-reduction of `CHANGE_MASK`, registered.
- `CHANGE_ACK`, in, 1: a one-cycle pulse clears `CHANGE_MASK`.

## Operation
- Reset (`RESETN`=0, asynchronous):
  - synchronizer flops, `STATE`, `RISE`, `FALL`, `CHANGE_MASK`, `CHANGED` and all counters are forced to 0.
  - Release is taken synchronously by the surrounding reset bridge; this block is not responsible for it.
- Per channel, with `s` as the synchronizer output:
  - If `s` equals `STATE`, the counter loads 0.
  - If `s` differs from `STATE` and the counter is below `DEBOUNCE_CYCLES-1`, the counter increments.
  - If `s` differs from `STATE` and the counter equals `DEBOUNCE_CYCLES-1`, `STATE` loads `s` and the counter loads 0.
- Any glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles is discarded and restarts the count.
- Counter width is clog2(`DEBOUNCE_CYCLES`), minimum 1 bit. The counter saturates by construction and never wraps.
- `RISE[i]` and `FALL[i]` are registered and asserted on the same edge `STATE[i]` changes, for exactly one cycle. `RISE[i]` and `FALL[i]` are never both high.
- Change mask: `CHANGE_MASK` next value is (`CHANGE_ACK` ? 0 : `CHANGE_MASK`) | (`RISE` next | `FALL` next).
  - A change accepted on the same edge as the ack is kept, so the new event wins.
- `CHANGED` follows `CHANGE_MASK` one cycle later.
- If an input is high at reset release, it produces a `RISE` after the normal latency. This is intended: firmware sees the initial level as an event.
- `CHANGE_ACK` held high continuously masks nothing permanently. Events still set the mask on the cycle they occur, and it clears on the next edge.

## Timing
- Count the first rising edge that samples a new stable `PAD_Y` level as edge 1. `STATE`, `RISE` and `FALL` update on edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
  - Defaults: edge 1002.
  - With `DEBOUNCE_CYCLES`=1, the filter is transparent and the update lands on edge `SYNC_STAGES+1`.
- `CHANGE_MASK` updates on the same edge as `STATE`. `CHANGED` updates one edge later.
- Ack-to-clear latency: `CHANGE_MASK` is 0 on the edge that samples `CHANGE_ACK`=1, unless a change is accepted on that same edge. `CHANGED` drops one edge after that.
- Channels are fully independent. Simultaneous changes on several channels each raise their own `RISE`/`FALL` bit on the same edge.
- Reset asserted mid-count discards the count with no pulse.

## Structure
- Shared package `io_cond_pkg`:
  - `IO_WIDTH` = 9.
  - `IO_DEBOUNCE_DEFAULT` = 1000.
  - a `cnt_width(n)` function, clog2 with minimum 1.
- Sub-module `io_debounce_ch`: one channel containing synchronizer, counter, `STATE` bit and edge pulses. It is generated `WIDTH` times.
- The top level holds only `CHANGE_MASK`, `CHANGED` and the ack logic.

## Test plan
- Reset: hold `RESETN`=0 with `PAD_Y`=9'h1FF. All outputs must read 0. Release reset with `DEBOUNCE_CYCLES`=4 and `SYNC_STAGES`=2: `STATE` reads 9'h1FF and `RISE` reads 9'h1FF for one cycle on edge 6; `CHANGED` rises on edge 7.
- Glitch rejection: with `DEBOUNCE_CYCLES`=4, pulse `PAD_Y[3]` high for 3 cycles, then low. `STATE`, `RISE` and `CHANGE_MASK` must stay 0.
- Falling edge: `PAD_Y[8]` goes 1→0 and stays low. `FALL` must read 9'h100 for exactly one cycle on edge 6, and `CHANGE_MASK[8]` must be set.
- Ack collision: with `CHANGE_MASK`=9'h001, pulse `CHANGE_ACK` on the edge where channel 2 is accepted. `CHANGE_MASK` must read 9'h004 and `CHANGED` must stay 1.
- Reset mid-count: assert `RESETN` after 3 of 4 debounce cycles. No pulse may appear, and the counter must restart from 0 after release.
- Independence: bounce all 9 inputs with random widths 1–10 cycles. A scoreboard model must match `STATE`, `RISE` and `FALL` cycle-for-cycle.
